// File: rtl/load_fill_forwarder.sv
// Tracks outstanding cache-line fills per AXI ID and forwards each returning R beat,
// tagged with its beat-aligned byte address, to the load result buffers one cycle later.
module load_fill_forwarder #(
    parameter int AXI_WIDTH = 128,
    parameter int BEATS     = 4,
    parameter int NUM_IDS   = 4,
    localparam int IDW      = $clog2(NUM_IDS)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 IN_fill_valid,
    input  logic [IDW-1:0]       IN_fill_id,
    input  logic [31:0]          IN_fill_addr,
    output logic [NUM_IDS-1:0]   OUT_busy,

    input  logic                 IN_r_valid,
    output logic                 OUT_r_ready,
    input  logic [IDW-1:0]       IN_r_id,
    input  logic [AXI_WIDTH-1:0] IN_r_data,
    input  logic [1:0]           IN_r_resp,
    input  logic                 IN_r_last,

    input  logic                 IN_stall,
    output logic                 OUT_fwd_valid,
    output logic [31:0]          OUT_fwd_addr,
    output logic [AXI_WIDTH-1:0] OUT_fwd_data,
    output logic                 OUT_fwd_err,

    output logic                 OUT_done_valid,
    output logic [IDW-1:0]       OUT_done_id,
    output logic                 OUT_proto_err
);

    localparam int OFFS       = $clog2(AXI_WIDTH / 8);
    localparam int BW         = $clog2(BEATS);
    localparam int LB         = OFFS + BW;
    localparam logic [BW:0] LAST_CNT = (BW + 1)'(BEATS - 1);
    localparam logic [BW:0] CNT_ONE  = (BW + 1)'(1);

    // Per-ID tracking entries
    logic [NUM_IDS-1:0] busy_q;
    logic [31-LB:0]     base_q  [NUM_IDS];
    logic [BW-1:0]      start_q [NUM_IDS];
    logic [BW:0]        cnt_q   [NUM_IDS];

    // R channel is valid/ready: a beat transfers on a cycle where IN_r_valid and
    // OUT_r_ready are both high; ready drops only when the forward path is stalled.
    logic           accept;
    logic           hit;
    logic           stray;
    logic           completing;
    logic           last_bad;
    logic           fill_conflict;
    logic           fill_take;
    logic [BW:0]    cur_cnt;
    logic [BW-1:0]  beat_idx;

    assign OUT_r_ready = !IN_stall && !rst;
    assign OUT_busy    = busy_q;

    assign accept     = IN_r_valid && OUT_r_ready;
    assign hit        = accept && busy_q[IN_r_id];
    assign stray      = accept && !busy_q[IN_r_id];
    assign completing = hit && IN_r_last;
    assign cur_cnt    = cnt_q[IN_r_id];
    assign beat_idx   = start_q[IN_r_id] + cur_cnt[BW-1:0];
    assign last_bad   = hit && (IN_r_last != (cur_cnt == LAST_CNT));

    // A busy ID may be re-registered only when its last beat retires this same cycle.
    assign fill_conflict = IN_fill_valid && busy_q[IN_fill_id]
                        && !(completing && (IN_r_id == IN_fill_id));
    assign fill_take     = IN_fill_valid && !fill_conflict;

    wire unused_fill_offs = ^IN_fill_addr[OFFS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            OUT_fwd_valid  <= 1'b0;
            OUT_fwd_addr   <= '0;
            OUT_fwd_data   <= '0;
            OUT_fwd_err    <= 1'b0;
            OUT_done_valid <= 1'b0;
            OUT_done_id    <= '0;
            OUT_proto_err  <= 1'b0;
            for (int i = 0; i < NUM_IDS; i++) begin
                base_q[i]  <= '0;
                start_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            OUT_fwd_valid  <= hit;
            OUT_done_valid <= completing;

            if (hit) begin
                OUT_fwd_addr       <= {base_q[IN_r_id], beat_idx, {OFFS{1'b0}}};
                OUT_fwd_data       <= IN_r_data;
                OUT_fwd_err        <= (IN_r_resp != 2'b00);
                cnt_q[IN_r_id]     <= cur_cnt + CNT_ONE;
            end

            if (completing) begin
                busy_q[IN_r_id] <= 1'b0;
                OUT_done_id     <= IN_r_id;
            end

            // Placed after completion so a same-cycle refill of that ID wins.
            if (fill_take) begin
                busy_q[IN_fill_id]  <= 1'b1;
                base_q[IN_fill_id]  <= IN_fill_addr[31:LB];
                start_q[IN_fill_id] <= IN_fill_addr[LB-1:OFFS];
                cnt_q[IN_fill_id]   <= '0;
            end

            if (fill_conflict || last_bad || stray)
                OUT_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_fill_forwarder.sv
// Randomized and directed bench for load_fill_forwarder against a line-address
// reference model kept per AXI ID.
module tb_load_fill_forwarder;

    localparam int AXI_WIDTH  = 128;
    localparam int BEATS      = 4;
    localparam int NUM_IDS    = 4;
    localparam int BEAT_BYTES = AXI_WIDTH / 8;
    localparam int LINE_BYTES = BEATS * BEAT_BYTES;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fill_valid = 1'b0;
    logic [1:0]   fill_id = '0;
    logic [31:0]  fill_addr = '0;
    logic [3:0]   busy;
    logic         r_valid = 1'b0;
    logic         r_ready;
    logic [1:0]   r_id = '0;
    logic [127:0] r_data = '0;
    logic [1:0]   r_resp = '0;
    logic         r_last = 1'b0;
    logic         stall = 1'b0;
    logic         fwd_valid;
    logic [31:0]  fwd_addr;
    logic [127:0] fwd_data;
    logic         fwd_err;
    logic         done_valid;
    logic [1:0]   done_id;
    logic         proto_err;

    load_fill_forwarder #(.AXI_WIDTH(AXI_WIDTH), .BEATS(BEATS), .NUM_IDS(NUM_IDS)) dut (
        .clk(clk), .rst(rst),
        .IN_fill_valid(fill_valid), .IN_fill_id(fill_id), .IN_fill_addr(fill_addr),
        .OUT_busy(busy),
        .IN_r_valid(r_valid), .OUT_r_ready(r_ready), .IN_r_id(r_id),
        .IN_r_data(r_data), .IN_r_resp(r_resp), .IN_r_last(r_last),
        .IN_stall(stall),
        .OUT_fwd_valid(fwd_valid), .OUT_fwd_addr(fwd_addr), .OUT_fwd_data(fwd_data),
        .OUT_fwd_err(fwd_err),
        .OUT_done_valid(done_valid), .OUT_done_id(done_id), .OUT_proto_err(proto_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]  m_line [NUM_IDS];
    int           m_crit [NUM_IDS];
    int           m_seen [NUM_IDS];
    logic [3:0]   m_busy;
    logic         m_perr;
    logic         e_fv, e_dv, e_err;
    logic [1:0]   e_did;
    logic [31:0]  e_addr;
    logic [127:0] e_data;

    task automatic model_reset();
        m_busy = '0; m_perr = 1'b0;
        e_fv = 1'b0; e_dv = 1'b0; e_err = 1'b0; e_did = '0;
        e_addr = '0; e_data = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            m_line[i] = '0; m_crit[i] = 0; m_seen[i] = 0;
        end
    endtask

    task automatic model_cycle();
        int k;
        e_fv = 1'b0;
        e_dv = 1'b0;
        if (r_valid && !stall) begin
            if (m_busy[r_id]) begin
                k      = (m_crit[r_id] + m_seen[r_id]) % BEATS;
                e_fv   = 1'b1;
                e_addr = m_line[r_id] + 32'(k * BEAT_BYTES);
                e_data = r_data;
                e_err  = (r_resp != 2'b00);
                if (r_last != (m_seen[r_id] == BEATS - 1)) m_perr = 1'b1;
                m_seen[r_id]++;
                if (r_last) begin
                    m_busy[r_id] = 1'b0;
                    e_dv  = 1'b1;
                    e_did = r_id;
                end
            end else begin
                m_perr = 1'b1;
            end
        end
        if (fill_valid) begin
            if (m_busy[fill_id]) m_perr = 1'b1;
            else begin
                m_busy[fill_id] = 1'b1;
                m_line[fill_id] = fill_addr & ~32'(LINE_BYTES - 1);
                m_crit[fill_id] = int'((fill_addr / BEAT_BYTES) % BEATS);
                m_seen[fill_id] = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("fwd_valid", fwd_valid, e_fv);
        check_eq("fwd_addr", fwd_addr, e_addr);
        check_eq("fwd_data", fwd_data, e_data);
        if (e_fv) check_eq("fwd_err", fwd_err, e_err);
        check_eq("done_valid", done_valid, e_dv);
        if (e_dv) check_eq("done_id", done_id, e_did);
        check_eq("busy", busy, m_busy);
        check_eq("proto_err", proto_err, m_perr);
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; drives one cycle of inputs and checks the result.
    task automatic step(input logic fv, input logic [1:0] fid, input logic [31:0] fa,
                        input logic rv, input logic [1:0] rid, input logic [127:0] rd,
                        input logic [1:0] rr, input logic rl, input logic st);
        fill_valid = fv; fill_id = fid; fill_addr = fa;
        r_valid = rv; r_id = rid; r_data = rd; r_resp = rr; r_last = rl; stall = st;
        #1;
        check_eq("r_ready", r_ready, !st);
        model_cycle();
        @(posedge clk); #1;
        compare_outputs();
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 128'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        fill_valid = 1'b0; r_valid = 1'b0; stall = 1'b0; r_last = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("r_ready_in_reset", r_ready, 1'b0);
        model_reset();
        @(posedge clk); #1;
        compare_outputs();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_random(input int cycles, input bit clean);
        logic fv, rv, rl, st;
        logic [1:0] fid, rid, rr;
        for (int c = 0; c < cycles; c++) begin
            st  = ($urandom_range(0, 3) == 0);
            rid = 2'($urandom_range(0, NUM_IDS - 1));
            fid = 2'($urandom_range(0, NUM_IDS - 1));
            rr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (clean) begin
                rv = m_busy[rid] && ($urandom_range(0, 9) < 6);
                rl = (m_seen[rid] == BEATS - 1);
                if (rv && rl && !st && $urandom_range(0, 1) == 1) fid = rid;
                fv = ($urandom_range(0, 9) < 3) &&
                     (!m_busy[fid] || (fid == rid && rv && rl && !st));
            end else begin
                rv = ($urandom_range(0, 9) < 6);
                rl = ($urandom_range(0, 3) == 0);
                fv = ($urandom_range(0, 9) < 3);
            end
            step(fv, fid, $urandom(), rv, rid, rand_data(), rr, rl, st);
        end
    endtask

    // ---------------- scoreboard for directed forward addresses ----------------
    logic [31:0] exp_q[$];

    task automatic beat_expect(input logic [1:0] rid, input logic last, input string tag);
        step(1'b0, 2'd0, 32'd0, 1'b1, rid, rand_data(), 2'd0, last, 1'b0);
        if (exp_q.size() == 0) check_eq({tag, "_queue_empty"}, 1'b1, 1'b0);
        else check_eq(tag, fwd_addr, exp_q.pop_front());
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Critical-word-first wrap within one line
        step(1'b1, 2'd1, 32'h8000_0024, 1'b0, 2'd0, 128'd0, 2'd0, 1'b0, 1'b0);
        check_eq("fill_busy1", busy, 4'b0010);
        exp_q = '{32'h8000_0020, 32'h8000_0030, 32'h8000_0000, 32'h8000_0010};
        for (int b = 0; b < BEATS; b++) beat_expect(2'd1, b == BEATS - 1, "wrap_addr");
        check_eq("wrap_done_valid", done_valid, 1'b1);
        check_eq("wrap_done_id", done_id, 2'd1);
        check_eq("wrap_busy_clear", busy, 4'b0000);
        idle();
        check_eq("done_one_cycle", done_valid, 1'b0);

        // Stall holds off beats without disturbing the counter
        step(1'b1, 2'd1, 32'h0000_0140, 1'b1, 2'd0, 128'd0, 2'd0, 1'b0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 2'd0, 32'd0, 1'b1, 2'd1, rand_data(), 2'd1, 1'b0, 1'b1);
            check_eq("stall_no_fwd", fwd_valid, 1'b0);
        end
        exp_q = '{32'h0000_0140, 32'h0000_0150, 32'h0000_0160, 32'h0000_0170};
        for (int b = 0; b < BEATS; b++) beat_expect(2'd1, b == BEATS - 1, "stall_resume_addr");
        check_eq("stall_perr", proto_err, 1'b0);

        // Interleaved streams on IDs 0 and 2
        step(1'b1, 2'd0, 32'h0000_1000, 1'b0, 2'd0, 128'd0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'h0000_2040, 1'b0, 2'd0, 128'd0, 2'd0, 1'b0, 1'b0);
        for (int b = 0; b < BEATS; b++) begin
            exp_q.push_back(32'h0000_1000 + 32'(b * 16));
            beat_expect(2'd0, b == BEATS - 1, "ilv_id0_addr");
            exp_q.push_back(32'h0000_2040 + 32'(b * 16));
            beat_expect(2'd2, b == BEATS - 1, "ilv_id2_addr");
        end
        check_eq("ilv_done_id2", done_id, 2'd2);

        // Last beat and refill on the same ID in one cycle
        step(1'b1, 2'd0, 32'h0000_1010, 1'b0, 2'd0, 128'd0, 2'd0, 1'b0, 1'b0);
        for (int b = 0; b < BEATS - 1; b++)
            step(1'b0, 2'd0, 32'd0, 1'b1, 2'd0, rand_data(), 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'h0000_3000, 1'b1, 2'd0, rand_data(), 2'd2, 1'b1, 1'b0);
        check_eq("refill_done", done_valid, 1'b1);
        check_eq("refill_busy0", busy[0], 1'b1);
        check_eq("refill_no_perr", proto_err, 1'b0);
        exp_q = '{32'h0000_3000};
        beat_expect(2'd0, 1'b0, "refill_first_addr");

        // Unmatched beat for idle ID 3
        step(1'b0, 2'd0, 32'd0, 1'b1, 2'd3, rand_data(), 2'd0, 1'b0, 1'b0);
        check_eq("stray_no_fwd", fwd_valid, 1'b0);
        check_eq("stray_perr", proto_err, 1'b1);
        idle();
        idle();
        check_eq("stray_perr_sticky", proto_err, 1'b1);

        // Reset in the middle of a fill
        do_reset();
        step(1'b1, 2'd2, 32'h0000_5000, 1'b0, 2'd0, 128'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'd0, 1'b1, 2'd2, rand_data(), 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'd0, 1'b1, 2'd2, rand_data(), 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 4'b0000);
        check_eq("midrst_fwd_valid", fwd_valid, 1'b0);
        check_eq("midrst_fwd_addr", fwd_addr, 32'd0);
        check_eq("midrst_fwd_data", fwd_data, 128'd0);
        check_eq("midrst_perr", proto_err, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 2'd0, 32'd0, 1'b1, 2'd2, rand_data(), 2'd0, 1'b0, 1'b0);
        check_eq("postrst_no_fwd", fwd_valid, 1'b0);
        check_eq("postrst_perr", proto_err, 1'b1);

        // Randomized traffic: well-formed segments, then unconstrained
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            run_random(150, 1'b1);
        end
        do_reset();
        run_random(300, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
